// File: rtl/roi_scan_ctrl.sv
// Sequenced serial scan controller around the fuzzer ROI: shift a stimulus vector in,
// apply it to din, wait a settle time, capture dout and shift the result out on sdo.
module roi_scan_ctrl #(
  parameter int DIN_N         = 256,
  parameter int DOUT_N        = 256,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              di,
  output logic              sdo,
  output logic              busy,
  output logic              done,
  output logic [DIN_N-1:0]  din,
  input  logic [DOUT_N-1:0] dout
);

  localparam int MAX_AB = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int MAXV   = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CW     = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

  // The counter holds "remaining cycles minus one", so a phase ends when it reads zero.
  localparam logic [CW-1:0] DIN_LD    = CW'(DIN_N - 1);
  localparam logic [CW-1:0] DOUT_LD   = CW'(DOUT_N - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    SETTLE,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t             state;
  logic [DIN_N-1:0]   din_shr;
  logic [DOUT_N-1:0]  dout_shr;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      din      <= '0;
      din_shr  <= '0;
      dout_shr <= '0;
      cnt      <= '0;
      sdo      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT_IN;
            cnt   <= DIN_LD;
            busy  <= 1'b1;
          end
        end
        SHIFT_IN: begin
          din_shr <= {din_shr[DIN_N-2:0], di};
          if (cnt == '0) begin
            state <= APPLY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        APPLY: begin
          din <= din_shr;
          if (SETTLE_CYCLES == 0) begin
            state <= CAPTURE;
          end else begin
            state <= SETTLE;
            cnt   <= SETTLE_LD;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAPTURE: begin
          // sdo is preloaded here so the first SHIFT_OUT cycle already shows the MSB.
          dout_shr <= dout;
          sdo      <= dout[DOUT_N-1];
          cnt      <= DOUT_LD;
          state    <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          dout_shr <= dout_shr << 1;
          if (cnt == '0) begin
            state <= DONE;
            sdo   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            sdo <= dout_shr[DOUT_N-2];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          sdo   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Directed bench for roi_scan_ctrl: 8-bit vectors, ROI modelled as dout = ~din,
// with a second instance built with zero settle cycles.
module tb_roi_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       di = 1'b0;
  logic       sdo, busy, done;
  logic [7:0] din, dout;
  logic       sdo0, busy0, done0;
  logic [7:0] din0, dout0;

  int passed = 0;
  int total  = 0;

  // Observations k = 0..21 taken 1 time unit after edge T+k (T = edge sampling start).
  logic [7:0] din_h  [0:21];
  logic       busy_h [0:21];
  logic       done_h [0:21];
  logic       sdo_h  [0:21];
  logic       done0_h[0:21];
  logic       sdo0_h [0:21];

  always #5 clk = ~clk;

  assign dout  = ~din;
  assign dout0 = ~din0;

  roi_scan_ctrl #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .di(di), .sdo(sdo),
    .busy(busy), .done(done), .din(din), .dout(dout)
  );

  roi_scan_ctrl #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .di(di), .sdo(sdo0),
    .busy(busy0), .done(done0), .din(din0), .dout(dout0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  // Runs one transaction; extra start pulses at edges p1/p2, reset at edge rst_k (-1 = none).
  task automatic drive_txn(input logic [7:0] vec, input int p1, input int p2, input int rst_k);
    for (int k = 0; k <= 21; k++) begin
      start = (k == 0 || k == p1 || k == p2);
      rst_n = (k != rst_k);
      di    = (k >= 1 && k <= 8) ? vec[8-k] : 1'b0;
      tick();
      din_h[k]   = din;
      busy_h[k]  = busy;
      done_h[k]  = done;
      sdo_h[k]   = sdo;
      done0_h[k] = done0;
      sdo0_h[k]  = sdo0;
    end
    start = 1'b0;
    rst_n = 1'b1;
    $display("txn vec=%h p1=%0d p2=%0d rst_k=%0d din=%h", vec, p1, p2, rst_k, din);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_din", din, 8'h00);
    chk("reset_sdo", {7'd0, sdo}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_done", {7'd0, done}, 8'h00);
    $display("test_reset done");
  endtask

  task automatic test_round_trip();
    logic [7:0] exp_do;
    exp_do = 8'h4D;
    drive_txn(8'hB2, -1, -1, -1);
    chk("rt_din_before_apply", din_h[8], 8'h00);
    chk("rt_din_applied", din_h[9], 8'hB2);
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("rt_sdo_k%0d", k), {7'd0, sdo_h[k]},
          {7'd0, (k >= 12 && k <= 19) ? exp_do[19-k] : 1'b0});
      chk($sformatf("rt_done_k%0d", k), {7'd0, done_h[k]}, {7'd0, k == 20});
      chk($sformatf("rt_busy_k%0d", k), {7'd0, busy_h[k]}, {7'd0, k <= 19});
    end
    $display("test_round_trip done");
  endtask

  task automatic test_settle_zero();
    logic [7:0] exp_do;
    exp_do = 8'h4D;
    do_reset();
    drive_txn(8'hB2, -1, -1, -1);
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("s0_sdo_k%0d", k), {7'd0, sdo0_h[k]},
          {7'd0, (k >= 10 && k <= 17) ? exp_do[17-k] : 1'b0});
      chk($sformatf("s0_done_k%0d", k), {7'd0, done0_h[k]}, {7'd0, k == 18});
    end
    $display("test_settle_zero done");
  endtask

  task automatic test_interlock();
    logic [7:0] exp_do;
    exp_do = 8'h4D;
    do_reset();
    // Stray pulses: one mid SHIFT_IN, one in the DONE cycle.
    drive_txn(8'hB2, 5, 21, -1);
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("il_done_k%0d", k), {7'd0, done_h[k]}, {7'd0, k == 20});
      chk($sformatf("il_busy_k%0d", k), {7'd0, busy_h[k]}, {7'd0, k <= 19});
    end
    for (int k = 12; k <= 19; k++)
      chk($sformatf("il_sdo_k%0d", k), {7'd0, sdo_h[k]}, {7'd0, exp_do[19-k]});
    $display("test_interlock done");
  endtask

  task automatic test_back_to_back();
    drive_txn(8'hFF, -1, -1, -1);
    chk("b2b_accepted", {7'd0, busy_h[0]}, 8'h01);
    for (int k = 0; k <= 8; k++)
      chk($sformatf("b2b_din_hold_k%0d", k), din_h[k], 8'hB2);
    chk("b2b_din_new", din_h[9], 8'hFF);
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("b2b_sdo_k%0d", k), {7'd0, sdo_h[k]}, 8'h00);
      chk($sformatf("b2b_done_k%0d", k), {7'd0, done_h[k]}, {7'd0, k == 20});
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_shift_in();
    drive_txn(8'h5A, -1, -1, -1);
    chk("rsi_prior_din", din_h[9], 8'h5A);
    drive_txn(8'hC3, -1, -1, 4);
    chk("rsi_din_pre_reset", din_h[3], 8'h5A);
    for (int k = 4; k <= 21; k++) begin
      chk($sformatf("rsi_din_k%0d", k), din_h[k], 8'h00);
      chk($sformatf("rsi_busy_k%0d", k), {7'd0, busy_h[k]}, 8'h00);
      chk($sformatf("rsi_sdo_k%0d", k), {7'd0, sdo_h[k]}, 8'h00);
      chk($sformatf("rsi_done_k%0d", k), {7'd0, done_h[k]}, 8'h00);
    end
    $display("test_reset_shift_in done");
  endtask

  task automatic test_reset_shift_out();
    drive_txn(8'hB2, -1, -1, 14);
    chk("rso_sdo_k12", {7'd0, sdo_h[12]}, 8'h00);
    chk("rso_sdo_k13", {7'd0, sdo_h[13]}, 8'h01);
    chk("rso_busy_k13", {7'd0, busy_h[13]}, 8'h01);
    for (int k = 14; k <= 21; k++) begin
      chk($sformatf("rso_sdo_k%0d", k), {7'd0, sdo_h[k]}, 8'h00);
      chk($sformatf("rso_busy_k%0d", k), {7'd0, busy_h[k]}, 8'h00);
      chk($sformatf("rso_din_k%0d", k), din_h[k], 8'h00);
      chk($sformatf("rso_done_k%0d", k), {7'd0, done_h[k]}, 8'h00);
    end
    $display("test_reset_shift_out done");
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_settle_zero();
    test_interlock();
    test_back_to_back();
    test_reset_shift_in();
    test_reset_shift_out();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
